receiver: RTL

//  Host->FPGA counterpart of the hash transmitter. Consumes the byte stream from avr_interface
//  (rx_data/new_rx_data), parses framed command packets and presents a 64-bit word plus command

---
 rtl/receiver_pkg.sv | 17 +
 rtl/rx_gap_timer.sv | 38 +++
 rtl/receiver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/receiver_pkg.sv
// rtl/receiver_pkg.sv - shared constants and state type for the framed byte receiver
package receiver_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_e;

endpackage

// File: rtl/rx_gap_timer.sv
// rtl/rx_gap_timer.sv - saturating inter-byte gap counter with expiry flag
module rx_gap_timer #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    // Holds at LIMIT so expiry stays asserted until the owner clears or disables it.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/receiver.sv
// rtl/receiver.sv - parses SYNC/CMD/payload/XOR-checksum frames from a byte strobe stream
module receiver
    import receiver_pkg::*;
#(
    parameter int         WORD_BYTES     = 8,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         TIMEOUT_W      = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_new_i,
    output logic [7:0]              cmd_o,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic                    valid_o,
    output logic                    err_o,
    output logic [1:0]              err_code_o,
    output logic                    busy_o
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BYTES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         xor_q, xor_d;
    logic [7:0]         shadow_cmd_q, shadow_cmd_d;
    logic [WORD_W-1:0]  shadow_word_q, shadow_word_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               gap_expired;

    rx_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_gap_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (rx_new_i),
        .enable_i  (state_q != IDLE),
        .expired_o (gap_expired)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        xor_d         = xor_q;
        shadow_cmd_d  = shadow_cmd_q;
        shadow_word_d = shadow_word_q;
        cmd_d         = cmd_q;
        word_d        = word_q;
        valid_d       = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;

        if (rx_new_i) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data_i == SYNC_BYTE) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    shadow_cmd_d = rx_data_i;
                    xor_d        = rx_data_i;
                    cnt_d        = '0;
                    state_d      = DATA;
                end
                DATA: begin
                    // SYNC_BYTE values here are payload, never a resync point.
                    shadow_word_d[8*cnt_q +: 8] = rx_data_i;
                    xor_d = xor_q ^ rx_data_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = CSUM;
                    end
                end
                CSUM: begin
                    if (rx_data_i == xor_q) begin
                        cmd_d   = shadow_cmd_q;
                        word_d  = shadow_word_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && gap_expired) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            xor_q         <= '0;
            shadow_cmd_q  <= '0;
            shadow_word_q <= '0;
            cmd_q         <= '0;
            word_q        <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            xor_q         <= xor_d;
            shadow_cmd_q  <= shadow_cmd_d;
            shadow_word_q <= shadow_word_d;
            cmd_q         <= cmd_d;
            word_q        <= word_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign cmd_o      = cmd_q;
    assign word_o     = word_q;
    assign valid_o    = valid_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign busy_o     = (state_q != IDLE);

endmodule
